rr_arb4: RTL and testbench
==========================

# rr_arb4

Four-requester round-robin arbiter with grant hold and timeout. Shares a single downstream resource among requesters `req[3:0]` and issues a one-hot grant plus its 2-bit binary index, the same one-hot-to-index mapping as the team's 4-to-2 encoders. It sits in front of the shared datapath and sequences ownership: one owner at a time, fair rotation, bounded hold time.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles per ownership. Legal range is 2..256.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  arbiter enable, active-high. While low, no new grant is issued and any held grant is revoked.
- `req`  in  4  request vector; bit i = requester i.
- `rel`  in  1  release strobe from the current owner. Sampled only in BUSY.
- `gnt`  out  4  one-hot grant, registered.
- `gnt_idx`  out  2  binary index of the granted requester; 0 when `gnt_vld`=0.
- `gnt_vld`  out  1  high iff `gnt` != 0.
- `tmo`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Internal state:
  - FSM states IDLE, BUSY, GAP.
  - `last[1:0]`: index of the most recent owner.
  - `cnt`: $clog2(HOLD_MAX) bits.
- Round-robin search order is `last`+1, +2, +3, +0, modulo 4, with wrap 3→0. The first set `req` bit in that order wins.
- IDLE:
  - If `en`=1 and `req`!=0, register the winner:
    - `gnt` gets the winner's one-hot.
    - `gnt_idx` gets the winner's index.
    - `gnt_vld`=1.
    - `last` gets the winner's index.
    - `cnt`=0.
    - Next state is BUSY.
  - Otherwise stay in IDLE with outputs 0.
- BUSY: outputs are held. Exit conditions are evaluated in this priority:
  1. `en`=0: go to IDLE and clear the grant. No `tmo`.
  2. `rel`=1, or the owner's `req` bit is 0: go to GAP and clear the grant.
  3. `cnt`==HOLD_MAX-1: go to GAP, clear the grant, and pulse `tmo`=1.
  4. Otherwise increment `cnt` and stay in BUSY.
- GAP: one idle cycle with outputs 0, then unconditionally go to IDLE. This guarantees a bubble between owners.
- Requests from non-owners during BUSY or GAP are ignored until IDLE. Requests are level-sensitive; no request latching.
- `rel` in IDLE or GAP is ignored.
- Release and timeout in the same cycle count as a release: no `tmo`.
- The owner holds the grant for at most HOLD_MAX cycles (`cnt` 0..HOLD_MAX-1).

## Timing
- Reset values (cycle after `rst` sampled high):
  - FSM = IDLE.
  - `gnt`=4'b0000, `gnt_idx`=2'b00, `gnt_vld`=0, `tmo`=0.
  - `last`=2'd3, so the first priority order is 0,1,2,3.
  - `cnt`=0.
- `rst` overrides everything, including mid-BUSY. The grant drops on the next edge and the rotation pointer returns to 3.
- Grant latency: `req` seen in IDLE at edge N → `gnt` valid after edge N+1 (1 cycle).
- Release latency: `rel` sampled high at edge M in BUSY → `gnt`=0 after M+1. GAP occupies M+1..M+2, and IDLE can issue a new grant visible after M+3.
  - Minimum spacing between the end of one grant and the start of the next is 2 cycles of `gnt_vld`=0.
- Timeout: with `req` held and no `rel`, `gnt_vld` is high for exactly HOLD_MAX cycles. `tmo` is high in the first cycle `gnt_vld` is low.
- `en` deassert in BUSY: `gnt` clears the next edge and the FSM goes directly to IDLE, skipping GAP.
- `gnt`, `gnt_idx` and `gnt_vld` are always mutually consistent. No combinational input→output path.

## Test plan
- Reset then `en`=1, `req`=4'b1111 held, owners pulse `rel` 2 cycles after each grant → grant sequence idx 0,1,2,3,0, each grant 3 cycles, 2 idle cycles between.
- `req`=4'b1010, `last`=1 after prior grant to 1; release → next grant is idx 3 (wrap order 2,3,0,1), then idx 1 after release.
- HOLD_MAX=4, `req`=4'b0100 held, no `rel` → `gnt`=4'b0100 for exactly 4 cycles, `tmo` pulse 1 cycle, then regrant idx 2 two cycles later.
- In the cycle with `cnt`=HOLD_MAX-1, assert `rel`=1 → grant drops, `tmo` stays 0. Separately, owner drops `req` mid-BUSY → grant clears next edge.
- `en`=0 mid-BUSY → `gnt`=0, `gnt_vld`=0 next edge, FSM IDLE, no `tmo`; with `en`=0 and `req`=4'b1111 → no grant for 10 cycles.
- Assert `rst` mid-BUSY with `req`=4'b1111 held → all outputs 0 next edge; after release of `rst`, first grant is idx 0.

Source files
------------

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant, hold-time limit
// and a mandatory one-cycle bubble between owners.
module rr_arb4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tmo
);

    localparam int unsigned CW = $clog2(HOLD_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StGap
    } state_e;

    state_e        state;
    logic [1:0]    last;
    logic [CW-1:0] cnt;

    logic          win_found;
    logic [1:0]    win_idx;
    logic [1:0]    cand;

    // Search last+1, last+2, last+3, last+0; the 2-bit add provides the 3->0 wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            gnt_vld <= 1'b0;
            tmo     <= 1'b0;
            last    <= 2'd3;
            cnt     <= '0;
        end else begin
            tmo <= 1'b0;
            case (state)
                StIdle: begin
                    if (en && win_found) begin
                        gnt     <= 4'b0001 << win_idx;
                        gnt_idx <= win_idx;
                        gnt_vld <= 1'b1;
                        last    <= win_idx;
                        cnt     <= '0;
                        state   <= StBusy;
                    end
                end
                StBusy: begin
                    if (!en) begin
                        gnt     <= 4'b0000;
                        gnt_idx <= 2'd0;
                        gnt_vld <= 1'b0;
                        state   <= StIdle;
                    end else if (rel || !req[gnt_idx]) begin
                        gnt     <= 4'b0000;
                        gnt_idx <= 2'd0;
                        gnt_vld <= 1'b0;
                        state   <= StGap;
                    end else if (cnt == CW'(HOLD_MAX - 1)) begin
                        gnt     <= 4'b0000;
                        gnt_idx <= 2'd0;
                        gnt_vld <= 1'b0;
                        tmo     <= 1'b1;
                        state   <= StGap;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StGap: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: directed scenarios plus randomized traffic, all checked against an
// ownership-level reference model evaluated once per clock edge.
module tb_rr_arb4;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       rel = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       tmo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: who owns the resource, for how many cycles, and whether a bubble is due.
    int m_owner = -1;
    int m_last  = 3;
    int m_held  = 0;
    bit m_gap   = 1'b0;
    bit m_tmo   = 1'b0;

    int seen[$];
    int vld_cnt;
    int tmo_cnt;

    rr_arb4 #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        m_tmo = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_last  = 3;
            m_held  = 0;
            m_gap   = 1'b0;
        end else if (m_owner >= 0) begin
            if (!en) begin
                m_owner = -1;
            end else if (rel || !req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_held >= HOLD) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_tmo   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (en && req != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic step();
        logic [3:0] eg;
        logic [1:0] ei;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        ei = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
        check_eq("outs", {24'b0, gnt, gnt_idx, gnt_vld, tmo},
                 {24'b0, eg, ei, (m_owner >= 0), m_tmo});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        rel = 1'b0;
        step();
        check_eq("rst_outs", {24'b0, gnt, gnt_idx, gnt_vld, tmo}, 32'd0);
        rst = 1'b0;
    endtask

    // Hold req, pulse rel when the owner has been granted rel_at cycles; record grant starts.
    task automatic run_rel(input logic [3:0] r, input int rel_at, input int cycles);
        logic prev;
        seen.delete();
        vld_cnt = 0;
        tmo_cnt = 0;
        req = r;
        en  = 1'b1;
        repeat (cycles) begin
            rel  = (m_owner >= 0 && m_held == rel_at);
            prev = gnt_vld;
            step();
            if (gnt_vld && !prev) seen.push_back(int'(gnt_idx));
            if (gnt_vld) vld_cnt++;
            if (tmo) tmo_cnt++;
        end
        rel = 1'b0;
    endtask

    task automatic check_seq(input string tag, input int exp_q[$]);
        check_eq({tag, "_len"}, 32'(seen.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < seen.size()) check_eq(tag, 32'(seen[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        // Full rotation with release after 3 grant cycles.
        apply_reset();
        run_rel(4'b1111, 3, 24);
        check_seq("rot_seq", '{0, 1, 2, 3, 0});

        // Sparse requests: wrap order after owner 1 picks 3, then back to 1.
        apply_reset();
        run_rel(4'b1010, 2, 10);
        check_seq("wrap_seq", '{1, 3, 1});

        // Timeout: HOLD grant cycles, one tmo pulse, regrant two cycles later.
        apply_reset();
        run_rel(4'b0100, 0, 6);
        check_eq("tmo_vld_cycles", 32'(vld_cnt), 32'(HOLD));
        check_eq("tmo_pulses", 32'(tmo_cnt), 32'd1);
        step();
        check_eq("tmo_regrant", {28'b0, gnt}, 32'b0100);

        // Release in the final hold cycle beats timeout.
        apply_reset();
        run_rel(4'b0001, HOLD, 6);
        check_eq("rel_last_vld", 32'(vld_cnt), 32'(HOLD));
        check_eq("rel_last_tmo", 32'(tmo_cnt), 32'd0);

        // Owner drops its request mid-hold.
        apply_reset();
        req = 4'b0010;
        en  = 1'b1;
        step();
        step();
        req = 4'b0000;
        step();
        check_eq("req_drop", {28'b0, gnt}, 32'd0);

        // Enable removed mid-hold, then no grants while disabled.
        apply_reset();
        req = 4'b1111;
        en  = 1'b1;
        step();
        step();
        en = 1'b0;
        step();
        check_eq("en_off", {29'b0, gnt_vld, tmo, |gnt}, 32'd0);
        repeat (10) begin
            step();
            check_eq("en_off_idle", {31'b0, gnt_vld}, 32'd0);
        end

        // Reset mid-hold with requester 1 owning; first grant afterwards is idx 0.
        apply_reset();
        run_rel(4'b1111, 2, 6);
        check_eq("pre_rst_owner", {29'b0, gnt_vld, gnt_idx}, {29'b0, 1'b1, 2'd1});
        rst = 1'b1;
        step();
        check_eq("mid_rst_outs", {24'b0, gnt, gnt_idx, gnt_vld, tmo}, 32'd0);
        rst = 1'b0;
        step();
        check_eq("post_rst_grant", {29'b0, gnt_vld, gnt_idx}, {29'b0, 1'b1, 2'd0});

        // Randomized traffic; requests change slowly so timeouts occur.
        apply_reset();
        repeat (2000) begin
            rst = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 4) == 0) req = 4'($urandom);
            rel = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
